// File: rtl/finn_latency_pkg.sv
// finn_latency_pkg: shared types and constants for the FINN latency probe.
package finn_latency_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_GAP, S_DONE} state_t;
    localparam int TRIAL_W = 8;
    localparam logic [63:0] DEF_PATTERN = 64'hDEADBEEFDEADBEEF;
endpackage

// File: rtl/finn_latency_stats.sv
// finn_latency_stats: last/min/max/sum latency registers with clear and update strobe.
module finn_latency_stats #(
    parameter int CNT_W = 32,
    parameter int SUM_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [CNT_W-1:0] lat,
    output logic [CNT_W-1:0] lat_last,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic [SUM_W-1:0] lat_sum
);
    always_ff @(posedge clk or negedge rst)
        if (!rst || clr) begin
            lat_last <= '0;
            lat_min  <= '1;
            lat_max  <= '0;
            lat_sum  <= '0;
        end else if (upd) begin
            lat_last <= lat;
            lat_min  <= lat < lat_min ? lat : lat_min;
            lat_max  <= lat > lat_max ? lat : lat_max;
            lat_sum  <= lat_sum + SUM_W'(lat);
        end
endmodule

// File: rtl/finn_latency_probe.sv
// finn_latency_probe: drives one stimulus beat per trial into the accelerator and
// measures handshake-to-result latency, accumulating min/max/sum over a run.
module finn_latency_probe
    import finn_latency_pkg::*;
#(
    parameter int              DATA_W     = 64,
    parameter int              OUT_W      = 8,
    parameter int              CNT_W      = 32,
    parameter int              NUM_TRIALS = 16,
    parameter int              GAP_CYCLES = 30,
    parameter int              TIMEOUT    = 4096,
    parameter logic [DATA_W-1:0] PATTERN  = DATA_W'(DEF_PATTERN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    input  logic [OUT_W-1:0]   s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [TRIAL_W-1:0] trial_cnt,
    output logic [CNT_W-1:0]   lat_last,
    output logic [CNT_W-1:0]   lat_min,
    output logic [CNT_W-1:0]   lat_max,
    output logic [CNT_W+7:0]   lat_sum,
    output logic [OUT_W-1:0]   result_last,
    output logic [TRIAL_W-1:0] stray_cnt
);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]   TMO        = CNT_W'(TIMEOUT);
    localparam logic [TRIAL_W-1:0] LAST_TRIAL = TRIAL_W'(NUM_TRIALS - 1);

    state_t             r_state, w_next;
    logic [TRIAL_W-1:0] r_trial, r_stray;
    logic [CNT_W-1:0]   r_lat_ctr, r_gap_ctr, w_lat;
    logic [OUT_W-1:0]   r_result;
    logic               r_tready, r_timeout;
    logic               w_hs_in, w_hs_out, w_got, w_tmo, w_clr;

    assign w_lat    = r_lat_ctr + CNT_W'(1);
    assign w_hs_in  = m_axis_tvalid & m_axis_tready;
    assign w_hs_out = s_axis_tvalid & r_tready;
    assign w_got    = r_state == S_WAIT && w_hs_out;
    // a result on the timeout cycle wins over the timeout
    assign w_tmo    = r_state == S_WAIT && !w_hs_out && w_lat == TMO;
    assign w_clr    = (r_state == S_IDLE || r_state == S_DONE) && start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = start ? S_SEND : r_state;
            S_SEND:         w_next = w_hs_in ? S_WAIT : S_SEND;
            S_WAIT:         w_next = w_got ? (r_trial == LAST_TRIAL ? S_DONE : (GAP_CYCLES == 0 ? S_SEND : S_GAP)) :
                                     w_tmo ? S_DONE : S_WAIT;
            S_GAP:          w_next = r_gap_ctr == GAP_LAST ? S_SEND : S_GAP;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state   <= S_IDLE;
            r_trial   <= '0;
            r_stray   <= '0;
            r_lat_ctr <= '0;
            r_gap_ctr <= '0;
            r_result  <= '0;
            r_tready  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_tready  <= 1'b1;
            r_lat_ctr <= r_state == S_WAIT ? w_lat : '0;
            r_gap_ctr <= r_state == S_GAP ? r_gap_ctr + CNT_W'(1) : '0;
            if (w_hs_out && r_state != S_WAIT && r_stray != '1)
                r_stray <= r_stray + TRIAL_W'(1);
            if (w_clr) begin
                r_trial   <= '0;
                r_result  <= '0;
                r_timeout <= 1'b0;
            end else if (w_got) begin
                r_trial  <= r_trial + TRIAL_W'(1);
                r_result <= s_axis_tdata;
            end else if (w_tmo)
                r_timeout <= 1'b1;
        end

    finn_latency_stats #(.CNT_W(CNT_W), .SUM_W(CNT_W + 8)) u_stats (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .upd      (w_got),
        .lat      (w_lat),
        .lat_last (lat_last),
        .lat_min  (lat_min),
        .lat_max  (lat_max),
        .lat_sum  (lat_sum)
    );

    assign m_axis_tvalid = r_state == S_SEND;
    assign m_axis_tdata  = m_axis_tvalid ? PATTERN ^ DATA_W'(r_trial) : '0;
    assign s_axis_tready = r_tready;
    assign busy          = r_state == S_SEND || r_state == S_WAIT || r_state == S_GAP;
    assign done          = r_state == S_DONE;
    assign timeout_err   = r_timeout;
    assign trial_cnt     = r_trial;
    assign result_last   = r_result;
    assign stray_cnt     = r_stray;
endmodule

// File: tb/tb_finn_latency_probe.sv
// tb_finn_latency_probe: two probe instances (4 trials/gap 5, 3 trials/gap 0) driven by
// per-instance accelerator models; a monitor scores stimulus beats and run summaries.
module tb_finn_latency_probe;
    typedef struct {
        logic [7:0]  cnt;
        logic [31:0] last, mn, mx;
        logic [39:0] sum;
        logic        to;
        logic [7:0]  res;
        int          tocyc;
    } sum_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic        start[2], m_tready[2], inj[2], m_tvalid[2], s_tv[2], s_tready[2];
    logic        busy[2], done[2], to[2];
    logic [63:0] m_tdata[2];
    logic [7:0]  s_tdata[2], tcnt[2], res[2], stray[2];
    logic [31:0] llast[2], lmin[2], lmax[2];
    logic [39:0] lsum[2];

    int          lat_q[2][$];
    logic [63:0] beat_q[2][$];
    sum_t        exp_q[2][$];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          hs_cyc[2];
    logic        pdone[2], stall_prev[2];
    logic [63:0] prev_data[2];

    always #5 clk = ~clk;

    finn_latency_probe #(.NUM_TRIALS(4), .GAP_CYCLES(5), .TIMEOUT(64)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tv[0]), .s_axis_tready(s_tready[0]),
        .busy(busy[0]), .done(done[0]), .timeout_err(to[0]), .trial_cnt(tcnt[0]),
        .lat_last(llast[0]), .lat_min(lmin[0]), .lat_max(lmax[0]), .lat_sum(lsum[0]),
        .result_last(res[0]), .stray_cnt(stray[0]));

    finn_latency_probe #(.NUM_TRIALS(3), .GAP_CYCLES(0), .TIMEOUT(64)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tv[1]), .s_axis_tready(s_tready[1]),
        .busy(busy[1]), .done(done[1]), .timeout_err(to[1]), .trial_cnt(tcnt[1]),
        .lat_last(llast[1]), .lat_min(lmin[1]), .lat_max(lmax[1]), .lat_sum(lsum[1]),
        .result_last(res[1]), .stray_cnt(stray[1]));

    // accelerator model: latency L pops per accepted beat, result sampled L edges later; L=0 never answers
    for (genvar g = 0; g < 2; g++) begin : acc
        int         rem = 0, cur = 0;
        logic       mv = 1'b0;
        logic [7:0] d = 8'h00;
        assign s_tv[g]    = mv | inj[g];
        assign s_tdata[g] = d;
        always @(posedge clk) begin
            int n;
            if (m_tvalid[g] && m_tready[g]) begin
                n = lat_q[g].size() > 0 ? lat_q[g].pop_front() : 0;
                cur = n;
            end else
                n = rem > 0 ? rem - 1 : 0;
            if (!rst) n = 0;
            rem = n;
            mv <= n == 1;
            d  <= 8'(cur) ^ 8'hA5;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic sum_t mk(input logic [7:0] c, input logic [31:0] l, input logic [31:0] mn,
                                input logic [31:0] mx, input logic [39:0] s, input logic t,
                                input logic [7:0] r, input int tc);
        sum_t e;
        e.cnt = c; e.last = l; e.mn = mn; e.mx = mx; e.sum = s; e.to = t; e.res = r; e.tocyc = tc;
        return e;
    endfunction

    always begin
        @(negedge clk);
        #1;
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (m_tvalid[g] && m_tready[g]) begin
                hs_cyc[g] = cyc;
                if (beat_q[g].size() == 0) chk($sformatf("beat_extra%0d", g), m_tdata[g], 64'hx);
                else chk($sformatf("beat%0d", g), m_tdata[g], beat_q[g].pop_front());
            end
            if (m_tvalid[g] && !m_tready[g] && stall_prev[g])
                chk($sformatf("stable%0d", g), m_tdata[g], prev_data[g]);
            stall_prev[g] = m_tvalid[g] && !m_tready[g];
            prev_data[g]  = m_tdata[g];
            if (done[g] && !pdone[g]) begin
                if (exp_q[g].size() == 0) chk($sformatf("done_extra%0d", g), {63'b0, done[g]}, 64'd0);
                else begin
                    sum_t e;
                    e = exp_q[g].pop_front();
                    chk($sformatf("trial_cnt%0d", g), tcnt[g], e.cnt);
                    chk($sformatf("lat_last%0d", g), llast[g], e.last);
                    chk($sformatf("lat_min%0d", g), lmin[g], e.mn);
                    chk($sformatf("lat_max%0d", g), lmax[g], e.mx);
                    chk($sformatf("lat_sum%0d", g), lsum[g], e.sum);
                    chk($sformatf("timeout_err%0d", g), to[g], e.to);
                    chk($sformatf("result_last%0d", g), res[g], e.res);
                    chk($sformatf("busy_done%0d", g), busy[g], 0);
                    if (e.tocyc != 0) chk($sformatf("timeout_cycles%0d", g), 64'(cyc - hs_cyc[g]), 64'(e.tocyc));
                end
            end
            pdone[g] = done[g];
        end
    end

    task automatic go(input int g, input int nb, input sum_t e, input bit push_exp);
        for (int i = 0; i < nb; i++) beat_q[g].push_back(64'hDEADBEEFDEADBEEF ^ 64'(i));
        if (push_exp) exp_q[g].push_back(e);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        int k = 0;
        while (!done[g] && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("done_wait%0d", g), done[g], 1);
        @(negedge clk);
    endtask

    task automatic push_lats(input int g, input int a, input int b, input int c, input int d);
        lat_q[g].push_back(a);
        if (b >= 0) lat_q[g].push_back(b);
        if (c >= 0) lat_q[g].push_back(c);
        if (d >= 0) lat_q[g].push_back(d);
    endtask

    task automatic chk_reset(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_tvalid%0d", tag, g), m_tvalid[g], 0);
            chk($sformatf("%s_tdata%0d", tag, g), m_tdata[g], 0);
            chk($sformatf("%s_tready%0d", tag, g), s_tready[g], 0);
            chk($sformatf("%s_busy%0d", tag, g), busy[g], 0);
            chk($sformatf("%s_done%0d", tag, g), done[g], 0);
            chk($sformatf("%s_to%0d", tag, g), to[g], 0);
            chk($sformatf("%s_cnt%0d", tag, g), tcnt[g], 0);
            chk($sformatf("%s_min%0d", tag, g), lmin[g], 32'hFFFFFFFF);
            chk($sformatf("%s_max%0d", tag, g), lmax[g], 0);
            chk($sformatf("%s_last%0d", tag, g), llast[g], 0);
            chk($sformatf("%s_sum%0d", tag, g), lsum[g], 0);
            chk($sformatf("%s_res%0d", tag, g), res[g], 0);
            chk($sformatf("%s_stray%0d", tag, g), stray[g], 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        start = '{1'b0, 1'b0};
        m_tready = '{1'b1, 1'b1};
        inj = '{1'b0, 1'b0};
        pdone = '{1'b0, 1'b0};
        stall_prev = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b1;
        @(negedge clk);
        chk("tready_out0", s_tready[0], 1);
        chk("tready_out1", s_tready[1], 1);

        push_lats(0, 12, 12, 12, 12);
        go(0, 4, mk(4, 12, 12, 12, 48, 0, 8'hA9, 0), 1);
        wait_done(0, 2000);

        m_tready[1] = 1'b0;
        push_lats(1, 5, 20, 9, -1);
        go(1, 3, mk(3, 9, 5, 20, 34, 0, 8'hAC, 0), 1);
        repeat (3) @(negedge clk);
        m_tready[1] = 1'b1;
        wait_done(1, 2000);

        push_lats(0, 0, -1, -1, -1);
        go(0, 1, mk(0, 0, 32'hFFFFFFFF, 0, 0, 1, 8'h00, 65), 1);
        wait_done(0, 500);

        push_lats(1, 64, 64, 1, -1);
        go(1, 3, mk(3, 1, 1, 64, 129, 0, 8'hA4, 0), 1);
        wait_done(1, 2000);

        push_lats(0, 12, 12, 12, 12);
        go(0, 4, mk(4, 12, 12, 12, 48, 0, 8'hA9, 0), 1);
        k = 0;
        while (tcnt[0] != 8'd1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("gap_reached", tcnt[0], 1);
        inj[0] = 1'b1;
        @(negedge clk);
        inj[0] = 1'b0;
        chk("stray_gap", stray[0], 1);
        chk("gap_sum", lsum[0], 12);
        chk("gap_cnt", tcnt[0], 1);
        wait_done(0, 2000);
        inj[0] = 1'b1;
        repeat (300) @(negedge clk);
        inj[0] = 1'b0;
        chk("stray_sat", stray[0], 255);
        chk("stray_cnt_kept", tcnt[0], 4);
        chk("stray_sum_kept", lsum[0], 48);

        push_lats(0, 0, -1, -1, -1);
        go(0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
        repeat (5) @(negedge clk);
        chk("in_wait_busy", busy[0], 1);
        chk("in_wait_tvalid", m_tvalid[0], 0);
        #2 rst = 1'b0;
        #1 chk_reset("abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_lats(0, 12, 12, 12, 12);
        go(0, 4, mk(4, 12, 12, 12, 48, 0, 8'hA9, 0), 1);
        wait_done(0, 2000);

        for (int g = 0; g < 2; g++) begin
            chk($sformatf("exp_left%0d", g), 64'(exp_q[g].size()), 0);
            chk($sformatf("beat_left%0d", g), 64'(beat_q[g].size()), 0);
            chk($sformatf("lat_left%0d", g), 64'(lat_q[g].size()), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
